// File: rtl/obsidian_writeback_unit.sv
// Obsidian writeback stage: selects ALU/load/link result, aligns and extends loads,
// holds it in a stallable output register for the register-file port, counts retirements.
module obsidian_writeback_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_unsigned,
  input  logic [OFF_W-1:0]  in_byte_off,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [DATA_W-1:0] in_link_data,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              flush,
  input  logic              wb_stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [CNT_W-1:0]  retire_q, retire_d;

  logic [OFF_W-1:0]  off_eff;
  logic [63:0]       raw64, shifted, load64;
  logic              sext;
  logic [DATA_W-1:0] result;
  logic              accept, consume, rd_is_zero;

  // Load alignment: offset bits finer than the access size are dropped, then
  // the datum is shifted down and extended in a 64-bit workspace.
  always_comb begin
    off_eff = '0;
    load64  = '0;
    case (in_mem_size)
      2'd0:    off_eff = in_byte_off;
      2'd1:    off_eff = in_byte_off & ~OFF_W'(1);
      2'd2:    off_eff = in_byte_off & ~OFF_W'(3);
      default: off_eff = '0;
    endcase
    raw64   = 64'(in_mem_data);
    shifted = raw64 >> {off_eff, 3'b000};
    sext    = !in_mem_unsigned;
    case (in_mem_size)
      2'd0:    load64 = {{56{sext & shifted[7]}},  shifted[7:0]};
      2'd1:    load64 = {{48{sext & shifted[15]}}, shifted[15:0]};
      2'd2:    load64 = {{32{sext & shifted[31]}}, shifted[31:0]};
      default: load64 = shifted;
    endcase
  end

  always_comb begin
    case (in_wb_sel)
      2'd1:    result = DATA_W'(load64);
      2'd2:    result = in_link_data;
      default: result = in_alu_data;
    endcase
  end

  assign in_ready   = !(wb_valid_q && wb_stall) && !flush;
  assign accept     = in_valid && in_ready;
  assign consume    = wb_valid_q && !wb_stall && !flush;
  assign rd_is_zero = (ZERO_REG != 0) && (in_rd == '0);

  // Output register: flush beats accept beats consume.
  always_comb begin
    wb_valid_d     = wb_valid_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    retire_d       = retire_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (accept) begin
      wb_valid_d     = 1'b1;
      wb_reg_write_d = in_reg_write && !rd_is_zero;
      wb_rd_d        = in_rd;
      wb_data_d      = result;
    end else if (consume) begin
      wb_valid_d = 1'b0;
    end
    if (consume) begin
      retire_d = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      retire_q       <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      retire_q       <= retire_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_obsidian_writeback_unit.sv
// Bench for obsidian_writeback_unit: a 32-bit (ZERO_REG=1) and a 64-bit (ZERO_REG=0)
// instance share one stimulus stream; expectations come from an arithmetic load model.
module tb_obsidian_writeback_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_reg_write, in_mem_unsigned, flush, wb_stall;
  logic [1:0]  in_wb_sel, in_mem_size;
  logic [2:0]  in_byte_off;
  logic [63:0] in_mem_data, in_alu_data, in_link_data;
  logic [4:0]  in_rd;

  logic        rdy32, v32, we32, rdy64, v64, we64;
  logic [4:0]  rd32, rd64;
  logic [31:0] d32, cnt32, cnt64;
  logic [63:0] d64;

  obsidian_writeback_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(32), .ZERO_REG(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned), .in_byte_off(in_byte_off[1:0]),
    .in_mem_data(in_mem_data[31:0]), .in_alu_data(in_alu_data[31:0]),
    .in_link_data(in_link_data[31:0]), .in_rd(in_rd), .flush(flush), .wb_stall(wb_stall),
    .wb_valid(v32), .wb_reg_write(we32), .wb_rd(rd32), .wb_data(d32), .retire_count(cnt32));

  obsidian_writeback_unit #(.DATA_W(64), .ADDR_W(5), .CNT_W(32), .ZERO_REG(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned), .in_byte_off(in_byte_off),
    .in_mem_data(in_mem_data), .in_alu_data(in_alu_data),
    .in_link_data(in_link_data), .in_rd(in_rd), .flush(flush), .wb_stall(wb_stall),
    .wb_valid(v64), .wb_reg_write(we64), .wb_rd(rd64), .wb_data(d64), .retire_count(cnt64));

  int total = 0;
  int bad   = 0;

  // Reference state per instance (index 0 = 32-bit, 1 = 64-bit).
  logic        mv[2], mwe[2];
  logic [4:0]  mrd[2];
  logic [63:0] mdata[2];
  int unsigned mcnt[2];
  logic        last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? '1 : 64'hFFFF_FFFF;
  endfunction

  // Load value from byte arithmetic: align offset down to the access size,
  // take that many bytes, sign-extend by subtracting 2^bits when negative.
  function automatic logic [63:0] ref_load(input int w, input logic [1:0] size, input logic uns,
                                          input logic [2:0] off, input logic [63:0] data);
    int nbytes, aoff;
    logic [63:0] v, m;
    case (size)
      2'd0: nbytes = 1;
      2'd1: nbytes = 2;
      2'd2: nbytes = 4;
      default: nbytes = w / 8;
    endcase
    aoff = (int'(off) % (w / 8));
    aoff = (aoff / nbytes) * nbytes;
    v = (data & wmask(w)) >> (8 * aoff);
    if (nbytes < 8) begin
      m = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & m;
      if (!uns && v[8*nbytes-1]) v = v - (64'd1 << (8 * nbytes));
    end
    return v & wmask(w);
  endfunction

  function automatic logic [63:0] ref_result(input int w);
    case (in_wb_sel)
      2'd1:    return ref_load(w, in_mem_size, in_mem_unsigned, in_byte_off, in_mem_data);
      2'd2:    return in_link_data & wmask(w);
      default: return in_alu_data & wmask(w);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; mwe[k] = 1'b0; mrd[k] = '0; mdata[k] = '0; mcnt[k] = 0;
    end
  endtask

  // One clock with the inputs currently driven: check ready, advance model, check outputs.
  task automatic cycle();
    logic rdy, acc, cons;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy  = !(mv[k] && wb_stall) && !flush;
      acc  = in_valid && rdy;
      cons = mv[k] && !wb_stall && !flush;
      chk(k == 0 ? "ready32" : "ready64", k == 0 ? rdy32 : rdy64, rdy);
      if (flush) mv[k] = 1'b0;
      else if (acc) begin
        mv[k]    = 1'b1;
        mwe[k]   = in_reg_write && !(k == 0 && in_rd == 5'd0);
        mrd[k]   = in_rd;
        mdata[k] = ref_result(k == 0 ? 32 : 64);
      end else if (cons) mv[k] = 1'b0;
      if (cons) mcnt[k]++;
      last_acc = acc;
    end
    @(posedge clk);
    @(negedge clk);
    chk("valid32", v32, mv[0]);
    chk("valid64", v64, mv[1]);
    chk("count32", cnt32, 64'(mcnt[0]));
    chk("count64", cnt64, 64'(mcnt[1]));
    if (mv[0]) begin
      chk("we32", we32, mwe[0]); chk("rd32", rd32, mrd[0]); chk("data32", d32, mdata[0]);
    end
    if (mv[1]) begin
      chk("we64", we64, mwe[1]); chk("rd64", rd64, mrd[1]); chk("data64", d64, mdata[1]);
    end
  endtask

  task automatic offer_alu(input logic [4:0] rd, input logic [63:0] data);
    in_valid = 1'b1; in_reg_write = 1'b1; in_wb_sel = 2'd0; in_rd = rd; in_alu_data = data;
  endtask

  task automatic do_load(input logic [1:0] size, input logic uns, input logic [2:0] off,
                         input logic [31:0] exp32);
    in_valid = 1'b1; in_reg_write = 1'b1; in_wb_sel = 2'd1; in_rd = 5'd9;
    in_mem_size = size; in_mem_unsigned = uns; in_byte_off = off;
    cycle();
    chk("load32_const", d32, exp32);
  endtask

  int unsigned saved;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_reg_write = 0; in_mem_unsigned = 0; flush = 0; wb_stall = 0;
    in_wb_sel = 0; in_mem_size = 0; in_byte_off = 0; in_mem_data = 0; in_alu_data = 0;
    in_link_data = 0; in_rd = 0; last_acc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", v32, 0); chk("rst_we", we32, 0); chk("rst_data", d64, 0);
    chk("rst_count", cnt32, 0); chk("rst_ready", rdy32, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back ALU bundles.
    offer_alu(5'd3, 64'h11); cycle();
    chk("alu_rd3", rd32, 3); chk("alu_d11", d32, 32'h11); chk("alu_we", we32, 1);
    offer_alu(5'd4, 64'h22); cycle();
    offer_alu(5'd5, 64'h33); cycle();
    chk("alu_d33", d32, 32'h33);
    in_valid = 1'b0; cycle();
    chk("alu_count3", cnt32, 3);

    // rd=0 suppression only on the ZERO_REG instance.
    offer_alu(5'd0, 64'h55); cycle();
    chk("rd0_valid", v32, 1); chk("rd0_we32", we32, 0); chk("rd0_we64", we64, 1);
    in_valid = 1'b0; cycle();
    chk("rd0_count", cnt32, 4);

    // Stall: A held three cycles while B waits, then swap on one edge.
    offer_alu(5'd7, 64'hAAAA); cycle();
    offer_alu(5'd8, 64'hBBBB); wb_stall = 1'b1;
    repeat (3) begin
      cycle();
      chk("stall_ready", rdy32, 0); chk("stall_dataA", d32, 32'hAAAA); chk("stall_rdA", rd32, 7);
    end
    wb_stall = 1'b0; cycle();
    chk("swap_dataB", d32, 32'hBBBB); chk("swap_count", cnt32, 5);
    offer_alu(5'd10, 64'hCCCC); cycle();
    offer_alu(5'd11, 64'hDDDD); cycle();
    in_valid = 1'b0; wb_stall = 1'b1;
    #1;
    chk("pre_rst_count", cnt32, 7); chk("pre_rst_valid", v32, 1);

    // Asynchronous reset mid-stall.
    rst_n = 1'b0; #1;
    chk("arst_valid", v32, 0); chk("arst_we", we32, 0); chk("arst_rd", rd32, 0);
    chk("arst_data", d32, 0); chk("arst_count", cnt32, 0); chk("arst_count64", cnt64, 0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; wb_stall = 1'b0; #1;
    chk("post_rst_ready", rdy32, 1);

    // Loads.
    in_mem_data = 64'hDEAD_BEEF_80FF_7F01;
    do_load(2'd0, 1'b0, 3'd3, 32'hFFFF_FF80);
    do_load(2'd0, 1'b1, 3'd2, 32'h0000_00FF);
    do_load(2'd1, 1'b0, 3'd2, 32'hFFFF_80FF);
    do_load(2'd1, 1'b1, 3'd0, 32'h0000_7F01);
    do_load(2'd2, 1'b0, 3'd0, 32'h80FF_7F01);
    do_load(2'd3, 1'b0, 3'd5, 32'h80FF_7F01);
    chk("full64", d64, 64'hDEAD_BEEF_80FF_7F01);
    in_wb_sel = 2'd2; in_link_data = 64'h1234_5678_9ABC_DEF0; cycle();
    chk("link32", d32, 32'h9ABC_DEF0);

    // Flush during stall with a new bundle offered.
    offer_alu(5'd12, 64'hEEEE); cycle();
    saved = cnt32;
    offer_alu(5'd13, 64'hFFFF); wb_stall = 1'b1; flush = 1'b1; cycle();
    chk("flush_valid", v32, 0); chk("flush_count", cnt32, 64'(saved));
    flush = 1'b0; wb_stall = 1'b0; in_valid = 1'b0; cycle();
    chk("flush_nocap", v32, 0);

    // Randomized traffic; a stalled offer is held until accepted.
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid        = ($urandom % 4) != 0;
        in_reg_write    = ($urandom % 4) != 0;
        in_wb_sel       = 2'($urandom);
        in_mem_size     = 2'($urandom);
        in_mem_unsigned = 1'($urandom);
        in_byte_off     = 3'($urandom);
        in_mem_data     = {$urandom, $urandom};
        in_alu_data     = {$urandom, $urandom};
        in_link_data    = {$urandom, $urandom};
        in_rd           = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
      end
      wb_stall = ($urandom % 4) == 0;
      flush    = ($urandom % 20) == 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
